axi_default_slave_w: RTL and testbench

//  Write-channel default slave (DS) for the AXI interconnect.
//  - Receives the AW/W traffic that the write address decoder steers to its "no slave hit" output (VALID_SS[6]).
//  - Completes every such transaction legally, then answers with BRESP=DECERR.
//  - Keeps the bus deadlock-free for unmapped addresses.

---
 rtl/axi_pkg.sv | 22 ++
 rtl/axi_dsw_errlog.sv | 53 +++++
 rtl/axi_default_slave_w.sv | 159 +++++++++++++++
 tb/tb_axi_default_slave_w.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI types and default widths for the write default slave
package axi_pkg;

  localparam int unsigned AXI_ID_WIDTH   = 8;
  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_LEN_WIDTH  = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } dsw_state_t;

endpackage

// File: rtl/axi_dsw_errlog.sv
// rtl/axi_dsw_errlog.sv - DECERR counter, last unmapped address and beat-count mismatch flag
module axi_dsw_errlog
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = AXI_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  aw_hs_i,
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  input  logic                  wlast_hs_i,
  input  logic [LEN_WIDTH:0]    beat_cnt_i,
  input  logic [LEN_WIDTH-1:0]  awlen_i,
  input  logic                  b_hs_i,
  output logic [15:0]           err_cnt_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  len_mismatch_o
);

  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  len_mismatch_q, len_mismatch_d;
  logic [LEN_WIDTH:0]    beats_expected;

  assign beats_expected = {1'b0, awlen_i} + 1'b1;

  always_comb begin
    err_cnt_d      = err_cnt_q;
    err_addr_d     = err_addr_q;
    len_mismatch_d = len_mismatch_q;
    if (b_hs_i && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    if (aw_hs_i) err_addr_d = aw_addr_i;
    if (wlast_hs_i && (beat_cnt_i != beats_expected)) len_mismatch_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      err_cnt_q      <= '0;
      err_addr_q     <= '0;
      len_mismatch_q <= 1'b0;
    end else begin
      err_cnt_q      <= err_cnt_d;
      err_addr_q     <= err_addr_d;
      len_mismatch_q <= len_mismatch_d;
    end
  end

  assign err_cnt_o      = err_cnt_q;
  assign err_addr_o     = err_addr_q;
  assign len_mismatch_o = len_mismatch_q;

endmodule

// File: rtl/axi_default_slave_w.sv
// rtl/axi_default_slave_w.sv - write-channel default slave answering unmapped AW/W with DECERR
// Optional error log ports: AXI_DSW_ERRLOG_EN
module axi_default_slave_w
  import axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = AXI_ID_WIDTH,
  parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = AXI_LEN_WIDTH
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID_S,
  input  logic [ADDR_WIDTH-1:0]   AWADDR_S,
  input  logic [LEN_WIDTH-1:0]    AWLEN_S,
  input  logic [2:0]              AWSIZE_S,
  input  logic [1:0]              AWBURST_S,
  input  logic                    AWVALID_S,
  output logic                    AWREADY_S,
  input  logic [DATA_WIDTH-1:0]   WDATA_S,
  input  logic [DATA_WIDTH/8-1:0] WSTRB_S,
  input  logic                    WLAST_S,
  input  logic                    WVALID_S,
  output logic                    WREADY_S,
  output logic [ID_WIDTH-1:0]     BID_S,
  output logic [1:0]              BRESP_S,
  output logic                    BVALID_S,
`ifdef AXI_DSW_ERRLOG_EN
  input  logic                    BREADY_S,
  output logic [15:0]             ERR_CNT,
  output logic [ADDR_WIDTH-1:0]   ERR_ADDR,
  output logic                    LEN_MISMATCH
`else
  input  logic                    BREADY_S
`endif
);

  localparam logic [LEN_WIDTH:0] BEAT_MAX = {1'b1, {LEN_WIDTH{1'b0}}};

  dsw_state_t           state_q, state_d;
  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic                 bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [ID_WIDTH-1:0]  bid_q, bid_d;
  resp_t                bresp_q, bresp_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH:0]   beat_cnt_q, beat_cnt_d;
  logic                 aw_hs, w_hs, wlast_hs, b_hs;

  assign aw_hs    = AWVALID_S && awready_q && (state_q == IDLE);
  assign w_hs     = WVALID_S && wready_q && (state_q == DATA);
  assign wlast_hs = w_hs && WLAST_S;
  assign b_hs     = BVALID_S && BREADY_S && (state_q == RESP);

  always_comb begin
    state_d    = state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    id_d       = id_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          id_d       = AWID_S;
          len_d      = AWLEN_S;
          beat_cnt_d = '0;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_cnt_d = (beat_cnt_q == BEAT_MAX) ? BEAT_MAX : beat_cnt_q + 1'b1;
        end
        // Only WLAST ends the burst; a wrong beat count is tolerated.
        if (wlast_hs) begin
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = DECERR;
          bid_d    = id_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          bvalid_d  = 1'b0;
          bresp_d   = OKAY;
          bid_d     = '0;
          awready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      id_q       <= '0;
      bid_q      <= '0;
      bresp_q    <= OKAY;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      id_q       <= id_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign AWREADY_S = awready_q;
  assign WREADY_S  = wready_q;
  assign BVALID_S  = bvalid_q;
  assign BID_S     = bid_q;
  assign BRESP_S   = bresp_q;

  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE_S, AWBURST_S, WDATA_S, WSTRB_S};

`ifdef AXI_DSW_ERRLOG_EN
  axi_dsw_errlog #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_errlog (
    .clk_i         (ACLK),
    .rstn_i        (ARESETn),
    .aw_hs_i       (aw_hs),
    .aw_addr_i     (AWADDR_S),
    .wlast_hs_i    (wlast_hs),
    .beat_cnt_i    (beat_cnt_d),
    .awlen_i       (len_q),
    .b_hs_i        (b_hs),
    .err_cnt_o     (ERR_CNT),
    .err_addr_o    (ERR_ADDR),
    .len_mismatch_o(LEN_MISMATCH)
  );
`else
  logic unused_errlog;
  assign unused_errlog = ^{AWADDR_S, len_q};
`endif

endmodule

// File: tb/tb_axi_default_slave_w.sv
// tb/tb_axi_default_slave_w.sv - self-checking bench for axi_default_slave_w
module tb_axi_default_slave_w;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  AWID_S;
  logic [31:0] AWADDR_S;
  logic [3:0]  AWLEN_S;
  logic [2:0]  AWSIZE_S;
  logic [1:0]  AWBURST_S;
  logic        AWVALID_S;
  logic        AWREADY_S;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WLAST_S;
  logic        WVALID_S;
  logic        WREADY_S;
  logic [7:0]  BID_S;
  logic [1:0]  BRESP_S;
  logic        BVALID_S;
  logic        BREADY_S;
`ifdef AXI_DSW_ERRLOG_EN
  logic [15:0] ERR_CNT;
  logic [31:0] ERR_ADDR;
  logic        LEN_MISMATCH;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_ids[$];

  axi_default_slave_w dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
`ifdef AXI_DSW_ERRLOG_EN
    .BREADY_S(BREADY_S), .ERR_CNT(ERR_CNT), .ERR_ADDR(ERR_ADDR), .LEN_MISMATCH(LEN_MISMATCH)
`else
    .BREADY_S(BREADY_S)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic       rstn, awv;
    logic [7:0] id;
    logic [3:0] len;
    logic       wv, wl, br;
    logic       e_awr, e_wr, e_bv;
    logic [7:0] e_bid;
    logic [1:0] e_bresp;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ARESETn = 1'b0; AWVALID_S = 0; WVALID_S = 0; WLAST_S = 0; BREADY_S = 0;
    repeat (2) tick();
    chk("reset_bvalid", BVALID_S, 0);
    ARESETn = 1'b1;
    tick();
    chk("awready_after_release", AWREADY_S, 1);
  endtask

  // One full transaction from a compliant master; checks every latency and hold rule.
  task automatic run_txn(input logic [7:0] id, input logic [3:0] len, input logic [31:0] addr,
                         input int nbeats, input bit toggle, input int bdelay, output int held);
    int bound, beats, ph;
    logic v, acc;
    AWID_S = id; AWLEN_S = len; AWADDR_S = addr; AWVALID_S = 1'b1;
    bound = 0;
    while (!AWREADY_S && bound < 20) begin tick(); bound++; end
    chk("aw_ready_wait", AWREADY_S, 1);
    exp_ids.push_back(id);
    tick();
    AWVALID_S = 1'b0; AWID_S = 8'($urandom);
    chk("wready_after_aw", WREADY_S, 1);
    chk("awready_low_in_data", AWREADY_S, 0);
    beats = 0; ph = 0; bound = 0;
    while (beats < nbeats && bound < 200) begin
      v = toggle ? (ph % 2 == 0) : ($urandom_range(0, 3) != 0);
      ph++;
      WVALID_S = v; WLAST_S = (beats == nbeats - 1); WDATA_S = $urandom;
      acc = v && WREADY_S;
      tick(); bound++;
      if (acc) beats++;
      if (beats < nbeats) chk("no_bvalid_mid_burst", BVALID_S, 0);
    end
    WVALID_S = 1'b0; WLAST_S = 1'b0;
    chk("beats_accepted", beats, nbeats);
    chk("bvalid_after_wlast", BVALID_S, 1);
    chk("bid", BID_S, exp_ids[0]);
    chk("bresp_decerr", BRESP_S, 2'b11);
    chk("wready_low_in_resp", WREADY_S, 0);
    held = 1;
    repeat (bdelay) begin
      AWVALID_S = $urandom_range(0, 1);
      tick();
      chk("b_held", {BVALID_S, BRESP_S, BID_S}, {1'b1, 2'b11, exp_ids[0]});
      chk("awready_low_in_resp", AWREADY_S, 0);
      held++;
    end
    AWVALID_S = 1'b0; BREADY_S = 1'b1;
    tick();
    BREADY_S = 1'b0;
    void'(exp_ids.pop_front());
    chk("b_done", {BVALID_S, BRESP_S, BID_S}, 0);
    chk("awready_after_b", AWREADY_S, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    AWADDR_S = 32'hFFFF_0000; AWSIZE_S = 3'd2; AWBURST_S = 2'b01;
    WDATA_S = '0; WSTRB_S = 4'hF; WLAST_S = 0; WVALID_S = 0; BREADY_S = 0;
    AWID_S = 0; AWLEN_S = 0; AWVALID_S = 0; ARESETn = 0;

    //            rstn awv id     len wv wl br   awr wr bv bid    bresp
    vecs[0]  = '{0, 1, 8'h15, 0, 0, 0, 0,  0, 0, 0, 8'h00, 2'b00};
    vecs[1]  = '{0, 1, 8'h15, 0, 0, 0, 0,  0, 0, 0, 8'h00, 2'b00};
    vecs[2]  = '{0, 1, 8'h15, 0, 0, 0, 0,  0, 0, 0, 8'h00, 2'b00};
    vecs[3]  = '{1, 0, 8'h15, 0, 0, 0, 0,  1, 0, 0, 8'h00, 2'b00};
    vecs[4]  = '{1, 1, 8'h15, 0, 0, 0, 0,  0, 1, 0, 8'h00, 2'b00};
    vecs[5]  = '{1, 0, 8'h00, 0, 1, 1, 0,  0, 0, 1, 8'h15, 2'b11};
    vecs[6]  = '{1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 8'h15, 2'b11};
    vecs[7]  = '{1, 0, 8'h00, 0, 0, 0, 1,  1, 0, 0, 8'h00, 2'b00};
    vecs[8]  = '{1, 0, 8'h00, 0, 1, 1, 1,  1, 0, 0, 8'h00, 2'b00};
    vecs[9]  = '{1, 1, 8'h22, 0, 1, 1, 1,  0, 1, 0, 8'h00, 2'b00};
    vecs[10] = '{1, 1, 8'h33, 0, 1, 1, 1,  0, 0, 1, 8'h22, 2'b11};
    vecs[11] = '{1, 0, 8'h00, 0, 0, 0, 1,  1, 0, 0, 8'h00, 2'b00};
    vecs[12] = '{1, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 8'h00, 2'b00};

    for (int i = 0; i < 13; i++) begin
      ARESETn = vecs[i].rstn; AWVALID_S = vecs[i].awv; AWID_S = vecs[i].id; AWLEN_S = vecs[i].len;
      WVALID_S = vecs[i].wv; WLAST_S = vecs[i].wl; BREADY_S = vecs[i].br;
      tick();
      chk($sformatf("vec%0d_awready", i), AWREADY_S, vecs[i].e_awr);
      chk($sformatf("vec%0d_wready", i), WREADY_S, vecs[i].e_wr);
      chk($sformatf("vec%0d_bvalid", i), BVALID_S, vecs[i].e_bv);
      chk($sformatf("vec%0d_bid", i), BID_S, vecs[i].e_bid);
      chk($sformatf("vec%0d_bresp", i), BRESP_S, vecs[i].e_bresp);
    end
    WVALID_S = 0; WLAST_S = 0; BREADY_S = 0; AWVALID_S = 0;

    // LEN=3 with WVALID toggling and BREADY held off; B must stay up five cycles.
    run_txn(8'h40, 4'd3, 32'hDEAD_0000, 4, 1'b1, 4, held);
    chk("b_held_cycles", held, 5);

    // AWVALID held across two transactions: second accepted only after first B.
    AWID_S = 8'h01; AWLEN_S = 0; AWVALID_S = 1'b1;
    tick();
    AWID_S = 8'h02;
    chk("b2b_first_taken", WREADY_S, 1);
    WVALID_S = 1; WLAST_S = 1;
    tick();
    WVALID_S = 0; WLAST_S = 0;
    chk("b2b_bid1", BID_S, 8'h01);
    chk("b2b_aw_blocked_resp", AWREADY_S, 0);
    tick();
    chk("b2b_aw_still_blocked", AWREADY_S, 0);
    BREADY_S = 1;
    tick();
    BREADY_S = 0;
    chk("b2b_awready_back", AWREADY_S, 1);
    chk("b2b_wready_idle", WREADY_S, 0);
    tick();
    AWVALID_S = 0;
    chk("b2b_second_taken", WREADY_S, 1);
    WVALID_S = 1; WLAST_S = 1;
    tick();
    WVALID_S = 0; WLAST_S = 0;
    chk("b2b_bid2", {BVALID_S, BID_S}, {1'b1, 8'h02});
    BREADY_S = 1;
    tick();
    BREADY_S = 0;
    chk("b2b_done", BVALID_S, 0);

    // Reset in the middle of a burst aborts it without a response.
    AWID_S = 8'h5A; AWLEN_S = 4'd3; AWVALID_S = 1;
    tick();
    AWVALID_S = 0; WVALID_S = 1; WLAST_S = 0;
    repeat (2) tick();
    chk("mid_burst_no_b", BVALID_S, 0);
    ARESETn = 0;
    tick();
    chk("abort_outputs_zero", {AWREADY_S, WREADY_S, BVALID_S, BID_S, BRESP_S}, 0);
    ARESETn = 1; WVALID_S = 0;
    tick();
    chk("abort_no_b", BVALID_S, 0);
    chk("abort_awready", AWREADY_S, 1);
    run_txn(8'h3A, 4'd0, 32'h0000_1000, 1, 1'b0, 1, held);

    // Randomised transactions against the scoreboard.
    for (int t = 0; t < 30; t++) begin
      logic [3:0] l;
      l = 4'($urandom_range(0, 15));
      run_txn(8'($urandom), l, $urandom, int'(l) + 1, 1'b0, $urandom_range(0, 4), held);
      repeat ($urandom_range(0, 2)) tick();
    end

`ifdef AXI_DSW_ERRLOG_EN
    do_reset();
    chk("errlog_reset", {ERR_CNT, LEN_MISMATCH}, 0);
    run_txn(8'h01, 4'd0, 32'h1000_0000, 1, 1'b0, 0, held);
    run_txn(8'h02, 4'd2, 32'h2000_0000, 3, 1'b0, 1, held);
    chk("errlog_cnt2", ERR_CNT, 16'd2);
    chk("errlog_no_mismatch", LEN_MISMATCH, 0);
    run_txn(8'h03, 4'd1, 32'h3000_0040, 1, 1'b0, 0, held);
    chk("errlog_cnt3", ERR_CNT, 16'd3);
    chk("errlog_addr", ERR_ADDR, 32'h3000_0040);
    chk("errlog_mismatch", LEN_MISMATCH, 1);
`else
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
